shake_byte_serializer: RTL

SHAKE_BYTE_SERIALIZER -- requirements
Module: shake_byte_serializer

---
 rtl/shake_byte_serializer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shake_byte_serializer.sv
// Byte FIFO + FSM feeding a SHAKE256 core 2 bits per cycle, MSB-first.
// Optional byte_count output enabled by defining SER_BYTE_COUNT_EN.
module shake_byte_serializer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_empty,
    output logic       in_ready,
    input  logic       core_done,
    output logic       start,
    output logic       enable,
    output logic [1:0] serial_in,
    output logic       serial_end_signal,
    output logic       busy
`ifdef SER_BYTE_COUNT_EN
    ,
    output logic [10:0] byte_count
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHUNK,
        S_GAP,
        S_END,
        S_BUSY
    } state_t;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          push;
    logic          pop;
    logic          byte_pop;
    logic [9:0]    head;

    state_t     state;
    state_t     state_nx;
    logic [1:0] cnt;
    logic [7:0] shreg;
    logic       cur_last;

    logic       start_d;
    logic       enable_d;
    logic       end_d;
    logic       busy_d;
    logic [1:0] serial_d;

    assign head     = mem[rd_ptr];
    assign push     = in_valid & in_ready;
    assign byte_pop = pop & ~head[9];
    assign count_nx = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_empty, in_last, in_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nx;
            in_ready <= (count_nx != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            cnt               <= 2'd0;
            shreg             <= 8'd0;
            cur_last          <= 1'b0;
            start             <= 1'b0;
            enable            <= 1'b0;
            serial_in         <= 2'b00;
            serial_end_signal <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 2'd0 : cnt + 2'd1;
            if (byte_pop) begin
                shreg    <= {head[5:0], 2'b00};
                cur_last <= head[8];
            end else if (state == S_CHUNK) begin
                shreg <= {shreg[5:0], 2'b00};
            end
            start             <= start_d;
            enable            <= enable_d;
            serial_in         <= serial_d;
            serial_end_signal <= end_d;
            busy              <= busy_d;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            S_IDLE:
                if (count != CW'(0))
                    state_nx = S_START;
            S_START:
                state_nx = S_WAIT;
            S_WAIT:
                if (cnt == 2'd1) begin
                    pop      = 1'b1;
                    state_nx = head[9] ? S_END : S_CHUNK;
                end
            S_CHUNK:
                if (cnt == 2'd3)
                    state_nx = S_GAP;
            S_GAP:
                if (cur_last) begin
                    state_nx = S_END;
                end else if (count != CW'(0)) begin
                    pop      = 1'b1;
                    state_nx = S_CHUNK;
                end
            S_END:
                state_nx = S_BUSY;
            S_BUSY:
                if (core_done)
                    state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it
    always_comb begin
        start_d  = (state_nx == S_START);
        enable_d = (state_nx == S_CHUNK);
        end_d    = (state_nx == S_END);
        busy_d   = (state_nx != S_IDLE);
        serial_d = 2'b00;
        if (byte_pop)
            serial_d = head[7:6];
        else if (state == S_CHUNK && state_nx == S_CHUNK)
            serial_d = shreg[7:6];
    end

`ifdef SER_BYTE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            byte_count <= 11'd0;
        else if (state_nx == S_START)
            byte_count <= 11'd0;
        else if (byte_pop && byte_count != 11'h7FF)
            byte_count <= byte_count + 11'd1;
    end
`endif

endmodule
